key_event_arbiter: RTL and testbench

Merges two key-event streams into the single `Key_Flag`/`Key_Value` channel that feeds the calculator/display logic. Source A is the debounced physical keypad and source B is the automatic result-replay injector. Each source is buffered in its own small FIFO. Output events are paced by a minimum inter-event gap, and a burst from one source is never interleaved with events from the other.

---
 rtl/key_event_arbiter_if.sv | 27 ++
 rtl/key_event_arbiter.sv | 168 ++++++++++++++++
 tb/tb_key_event_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_arbiter_if.sv
// Merged key-event channel: two source strobes/codes in, one paced strobe/code out,
// plus overflow and status flags.
interface key_event_arbiter_if #(
  parameter int unsigned CODE_W = 4
);
  logic              Key_Flag_a;
  logic [CODE_W-1:0] Key_Value_a;
  logic              Key_Flag_b;
  logic [CODE_W-1:0] Key_Value_b;
  logic              Ovf_clr;
  logic              Key_Flag;
  logic [CODE_W-1:0] Key_Value;
  logic              Grant_src;
  logic              Ovf_a;
  logic              Ovf_b;
  logic              Busy;

  modport master (
    output Key_Flag_a, Key_Value_a, Key_Flag_b, Key_Value_b, Ovf_clr,
    input  Key_Flag, Key_Value, Grant_src, Ovf_a, Ovf_b, Busy
  );

  modport slave (
    input  Key_Flag_a, Key_Value_a, Key_Flag_b, Key_Value_b, Ovf_clr,
    output Key_Flag, Key_Value, Grant_src, Ovf_a, Ovf_b, Busy
  );
endinterface

// File: rtl/key_event_arbiter.sv
// Merges keypad (A) and replay (B) key events into one paced channel; each source has
// its own FIFO and the current burst owner keeps the channel until its FIFO drains.
module key_event_arbiter #(
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 250000
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  key_event_arbiter_if.slave   kev
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PTR_W:0]   FullCnt = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
  localparam logic [CNT_W-1:0] GapOne  = CNT_W'(1);
  // Pop (IDLE) and flag (ISSUE) edges account for two of the gap cycles, the
  // terminal-zero cycle for the third.
  localparam logic [CNT_W-1:0] GapLoad = CNT_W'((GAP_CYCLES > 3) ? GAP_CYCLES - 3 : 0);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                r_owner, w_owner_d;
  logic [CODE_W-1:0]   r_hold, w_hold_d;
  logic                r_flag, w_flag_d;
  logic [CODE_W-1:0]   r_value, w_value_d;
  logic                r_ovf_a, r_ovf_b;

  logic [CODE_W-1:0]   r_mem_a [FIFO_DEPTH];
  logic [CODE_W-1:0]   r_mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wp_a, r_rp_a, r_wp_b, r_rp_b;
  logic [PTR_W:0]      r_n_a, r_n_b;

  logic                w_empty_a, w_empty_b, w_full_a, w_full_b;
  logic                w_pop_a, w_pop_b, w_push_a, w_push_b, w_drop_a, w_drop_b;
  logic [CODE_W-1:0]   w_head_a, w_head_b;

  always_comb begin
    w_empty_a = (r_n_a == '0);
    w_empty_b = (r_n_b == '0);
    w_full_a  = (r_n_a == FullCnt);
    w_full_b  = (r_n_b == FullCnt);
    w_head_a  = r_mem_a[r_rp_a];
    w_head_b  = r_mem_b[r_rp_b];
  end

  // A full FIFO still accepts a push when the same edge pops it.
  always_comb begin
    w_push_a = kev.Key_Flag_a & (~w_full_a | w_pop_a);
    w_push_b = kev.Key_Flag_b & (~w_full_b | w_pop_b);
    w_drop_a = kev.Key_Flag_a & w_full_a & ~w_pop_a;
    w_drop_b = kev.Key_Flag_b & w_full_b & ~w_pop_b;
  end

  always_ff @(posedge Clk) begin
    if (w_push_a) r_mem_a[r_wp_a] <= kev.Key_Value_a;
    if (w_push_b) r_mem_b[r_wp_b] <= kev.Key_Value_b;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wp_a <= '0;
      r_rp_a <= '0;
      r_n_a  <= '0;
      r_wp_b <= '0;
      r_rp_b <= '0;
      r_n_b  <= '0;
    end else begin
      if (w_push_a) r_wp_a <= r_wp_a + PtrOne;
      if (w_pop_a)  r_rp_a <= r_rp_a + PtrOne;
      if (w_push_b) r_wp_b <= r_wp_b + PtrOne;
      if (w_pop_b)  r_rp_b <= r_rp_b + PtrOne;
      unique case ({w_push_a, w_pop_a})
        2'b10:   r_n_a <= r_n_a + CntOne;
        2'b01:   r_n_a <= r_n_a - CntOne;
        default: r_n_a <= r_n_a;
      endcase
      unique case ({w_push_b, w_pop_b})
        2'b10:   r_n_b <= r_n_b + CntOne;
        2'b01:   r_n_b <= r_n_b - CntOne;
        default: r_n_b <= r_n_b;
      endcase
    end
  end

  // Overflow wins over a simultaneous clear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ovf_a <= 1'b0;
      r_ovf_b <= 1'b0;
    end else begin
      r_ovf_a <= (r_ovf_a & ~kev.Ovf_clr) | w_drop_a;
      r_ovf_b <= (r_ovf_b & ~kev.Ovf_clr) | w_drop_b;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_owner_d = r_owner;
    w_hold_d  = r_hold;
    w_flag_d  = 1'b0;
    w_value_d = r_value;
    w_pop_a   = 1'b0;
    w_pop_b   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_owner ? !w_empty_b : !w_empty_a) begin
          w_pop_a   = ~r_owner;
          w_pop_b   = r_owner;
          w_hold_d  = r_owner ? w_head_b : w_head_a;
          w_state_d = StIssue;
        end else if (!w_empty_a) begin
          w_pop_a   = 1'b1;
          w_hold_d  = w_head_a;
          w_owner_d = 1'b0;
          w_state_d = StIssue;
        end else if (!w_empty_b) begin
          w_pop_b   = 1'b1;
          w_hold_d  = w_head_b;
          w_owner_d = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        w_flag_d  = 1'b1;
        w_value_d = r_hold;
        w_cnt_d   = GapLoad;
        w_state_d = StGap;
      end
      StGap: begin
        if (r_cnt == '0) w_state_d = StIdle;
        else             w_cnt_d   = r_cnt - GapOne;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_hold  <= '0;
      r_flag  <= 1'b0;
      r_value <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_owner <= w_owner_d;
      r_hold  <= w_hold_d;
      r_flag  <= w_flag_d;
      r_value <= w_value_d;
    end
  end

  assign kev.Key_Flag  = r_flag;
  assign kev.Key_Value = r_value;
  assign kev.Grant_src = r_owner;
  assign kev.Ovf_a     = r_ovf_a;
  assign kev.Ovf_b     = r_ovf_b;
  assign kev.Busy      = !w_empty_a || !w_empty_b || (r_state != StIdle);

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with GAP_CYCLES=8, FIFO_DEPTH=4.
module tb_key_event_arbiter;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 8;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  key_event_arbiter_if #(.CODE_W(CW)) kev ();

  key_event_arbiter #(
    .CODE_W    (CW),
    .FIFO_DEPTH(DEPTH),
    .GAP_CYCLES(GAP)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .kev  (kev)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic fa, input logic [CW-1:0] va, input logic fb,
                       input logic [CW-1:0] vb, input logic clr);
    kev.Key_Flag_a  = fa;
    kev.Key_Value_a = va;
    kev.Key_Flag_b  = fb;
    kev.Key_Value_b = vb;
    kev.Ovf_clr     = clr;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    Rst_n = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    Rst_n = 1'b0;
    step();
    total++;
    if ({kev.Key_Flag, kev.Key_Value, kev.Grant_src, kev.Ovf_a, kev.Ovf_b, kev.Busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {kev.Key_Flag, kev.Key_Value,
               kev.Grant_src, kev.Ovf_a, kev.Ovf_b, kev.Busy});
    end
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (kev.Key_Flag !== 1'b0 || kev.Busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle i=%0d flag=%b busy=%b want 0 0", i, kev.Key_Flag, kev.Busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(i == 0, 4'h5, 1'b0, '0, 1'b0);
      step();
      total++;
      if (kev.Key_Flag !== (i == 2)) begin
        bad++;
        $display("FAIL single_flag i=%0d got=%b want=%b", i, kev.Key_Flag, (i == 2));
      end
      total++;
      if (kev.Busy !== (i <= 7)) begin
        bad++;
        $display("FAIL single_busy i=%0d got=%b want=%b", i, kev.Busy, (i <= 7));
      end
      if (i >= 2) begin
        total++;
        if (kev.Key_Value !== 4'h5 || kev.Grant_src !== 1'b0) begin
          bad++;
          $display("FAIL single_value i=%0d got=%h/%b want=5/0", i, kev.Key_Value,
                   kev.Grant_src);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(i == 0, 4'h3, i == 0, 4'hC, 1'b0);
      step();
      total++;
      if (kev.Key_Flag !== (i == 2 || i == 10)) begin
        bad++;
        $display("FAIL simul_flag i=%0d got=%b want=%b", i, kev.Key_Flag, (i == 2 || i == 10));
      end
      if (i == 2 || i == 10) begin
        total++;
        if (kev.Key_Value !== ((i == 2) ? 4'h3 : 4'hC) || kev.Grant_src !== (i == 10)) begin
          bad++;
          $display("FAIL simul_value i=%0d got=%h/%b want=%h/%b", i, kev.Key_Value,
                   kev.Grant_src, (i == 2) ? 4'h3 : 4'hC, (i == 10));
        end
      end
    end
    total++;
    if (kev.Busy !== 1'b0) begin
      bad++;
      $display("FAIL simul_busy_end got=%b want=0", kev.Busy);
    end
  endtask

  task automatic test_burst_lock();
    logic [CW-1:0] vals [4] = '{4'h1, 4'h2, 4'h3, 4'h9};
    logic          grts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic          exp_f;
    int            k;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      drive(i == 3, 4'h9, i < 3, CW'(i + 1), 1'b0);
      step();
      exp_f = (i >= 2) && (i <= 26) && ((i - 2) % 8 == 0);
      total++;
      if (kev.Key_Flag !== exp_f) begin
        bad++;
        $display("FAIL burst_flag i=%0d got=%b want=%b", i, kev.Key_Flag, exp_f);
      end
      if (exp_f) begin
        k = (i - 2) / 8;
        total++;
        if (kev.Key_Value !== vals[k] || kev.Grant_src !== grts[k]) begin
          bad++;
          $display("FAIL burst_value i=%0d got=%h/%b want=%h/%b", i, kev.Key_Value,
                   kev.Grant_src, vals[k], grts[k]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic exp_f;
    do_reset();
    for (int i = 0; i < 46; i++) begin
      drive(i < 6, CW'(i), 1'b0, '0, i == 45);
      step();
      exp_f = (i >= 2) && (i <= 34) && ((i - 2) % 8 == 0);
      total++;
      if (kev.Key_Flag !== exp_f) begin
        bad++;
        $display("FAIL ovf_flag i=%0d got=%b want=%b", i, kev.Key_Flag, exp_f);
      end
      if (exp_f) begin
        total++;
        if (kev.Key_Value !== CW'((i - 2) / 8) || kev.Grant_src !== 1'b0) begin
          bad++;
          $display("FAIL ovf_value i=%0d got=%h/%b want=%h/0", i, kev.Key_Value,
                   kev.Grant_src, CW'((i - 2) / 8));
        end
      end
      total++;
      if (kev.Ovf_a !== (i >= 5 && i < 45) || kev.Ovf_b !== 1'b0) begin
        bad++;
        $display("FAIL ovf_flags i=%0d got a=%b b=%b want a=%b b=0", i, kev.Ovf_a, kev.Ovf_b,
                 (i >= 5 && i < 45));
      end
      if (i == 39 || i == 40) begin
        total++;
        if (kev.Busy !== (i == 39)) begin
          bad++;
          $display("FAIL ovf_busy i=%0d got=%b want=%b", i, kev.Busy, (i == 39));
        end
      end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, i < 3, CW'(i + 1), 1'b0);
      step();
    end
    total++;
    if (kev.Busy !== 1'b1 || kev.Key_Value !== 4'h1 || kev.Grant_src !== 1'b1) begin
      bad++;
      $display("FAIL mid_prereset got busy=%b val=%h grant=%b want 1 1 1", kev.Busy,
               kev.Key_Value, kev.Grant_src);
    end
    Rst_n = 1'b0;
    #1;
    total++;
    if ({kev.Key_Flag, kev.Key_Value, kev.Grant_src, kev.Ovf_a, kev.Ovf_b, kev.Busy} !== '0) begin
      bad++;
      $display("FAIL mid_async_reset got=%b want=0", {kev.Key_Flag, kev.Key_Value,
               kev.Grant_src, kev.Ovf_a, kev.Ovf_b, kev.Busy});
    end
    step();
    step();
    Rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (kev.Key_Flag !== 1'b0 || kev.Busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_quiet i=%0d flag=%b busy=%b want 0 0", i, kev.Key_Flag, kev.Busy);
      end
    end
    // Owner must be back at A, so A wins a tie even though B owned the old burst.
    for (int i = 0; i < 12; i++) begin
      drive(i == 0, 4'h7, i == 0, 4'h6, 1'b0);
      step();
      total++;
      if (kev.Key_Flag !== (i == 2 || i == 10)) begin
        bad++;
        $display("FAIL mid_flag i=%0d got=%b want=%b", i, kev.Key_Flag, (i == 2 || i == 10));
      end
      if (i == 2 || i == 10) begin
        total++;
        if (kev.Key_Value !== ((i == 2) ? 4'h7 : 4'h6) || kev.Grant_src !== (i == 10)) begin
          bad++;
          $display("FAIL mid_value i=%0d got=%h/%b want=%h/%b", i, kev.Key_Value,
                   kev.Grant_src, (i == 2) ? 4'h7 : 4'h6, (i == 10));
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    test_reset();
    test_single();
    test_simultaneous();
    test_burst_lock();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
